// File: rtl/gates_sequencer.sv
// gates_sequencer: self-test sweep for the combinational gates block.
// Walks {A,B} through all four combinations, captures the 8-bit response
// of each into a 32-bit truth table and flags differences from golden.
module gates_sequencer #(
    parameter int SETTLE = 2,
    parameter int DWELL  = 50_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        stop,
    input  logic        mode,
    input  logic        step,
    input  logic [7:0]  gate_out,
    output logic        A,
    output logic        B,
    output logic [1:0]  idx,
    output logic        busy,
    output logic        done,
    output logic [31:0] tt,
    output logic        tt_valid,
    output logic [3:0]  err_mask
);

    localparam int MAXC = (SETTLE > DWELL) ? SETTLE : DWELL;
    localparam int CW   = $clog2(MAXC) + 1;
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE - 1);
    localparam logic [CW-1:0] DWELL_LAST  = CW'(DWELL - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SETTLE, S_CAPTURE, S_DWELL, S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      idx_q, idx_d;
    logic [31:0]     tt_q, tt_d;
    logic            tt_valid_q, tt_valid_d;
    logic [3:0]      err_q, err_d;
    logic            mode_q, mode_d;
    logic [2:0]      step_sync_q;
    logic            step_rise;
    logic            dwell_exit;

    // Expected gates response for input combination k = {A,B}.
    function automatic logic [7:0] golden(input logic [1:0] k);
        logic a, b;
        a = k[1];
        b = k[0];
        return {~(a ^ b), a ^ b, ~(a | b), ~(a & b), a | b, a & b, ~b, ~a};
    endfunction

    // Two synchroniser flops plus one history flop for rising-edge detect.
    assign step_rise  = step_sync_q[1] & ~step_sync_q[2];
    assign dwell_exit = mode_q ? step_rise : (cnt_q == DWELL_LAST);

    // State, counter, step synchroniser and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            tt_q        <= '0;
            tt_valid_q  <= 1'b0;
            err_q       <= '0;
            mode_q      <= 1'b0;
            step_sync_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            tt_q        <= tt_d;
            tt_valid_q  <= tt_valid_d;
            err_q       <= err_d;
            mode_q      <= mode_d;
            step_sync_q <= {step_sync_q[1:0], step};
        end
    end

    // Next-state and phase counter; stop aborts any sweep phase except DONE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (start && !stop) state_d = S_SETTLE;
            S_SETTLE:  if (stop) state_d = S_IDLE;
                       else if (cnt_q == SETTLE_LAST) state_d = S_CAPTURE;
            S_CAPTURE: state_d = stop ? S_IDLE : S_DWELL;
            S_DWELL:   if (stop) state_d = S_IDLE;
                       else if (dwell_exit) state_d = (idx_q == 2'd3) ? S_DONE : S_SETTLE;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase

        // Counter restarts on every state entry; it only runs where it is timed.
        cnt_d = '0;
        if (state_d == state_q &&
            (state_q == S_SETTLE || (state_q == S_DWELL && !mode_q)))
            cnt_d = cnt_q + 1'b1;
    end

    // Datapath updates: combination index, captures, error flags, valid.
    always_comb begin
        idx_d      = idx_q;
        tt_d       = tt_q;
        tt_valid_d = tt_valid_q;
        err_d      = err_q;
        mode_d     = mode_q;
        case (state_q)
            S_IDLE: begin
                if (start && !stop) begin
                    idx_d      = 2'd0;
                    tt_valid_d = 1'b0;
                    err_d      = '0;
                    mode_d     = mode;
                end
            end
            S_SETTLE: if (stop) idx_d = 2'd0;
            S_CAPTURE: begin
                if (stop) begin
                    idx_d = 2'd0;
                end else begin
                    tt_d[{idx_q, 3'b000} +: 8] = gate_out;
                    if (gate_out != golden(idx_q)) err_d[idx_q] = 1'b1;
                end
            end
            S_DWELL: begin
                if (stop) idx_d = 2'd0;
                else if (dwell_exit && idx_q != 2'd3) idx_d = idx_q + 2'd1;
            end
            S_DONE: begin
                tt_valid_d = 1'b1;
                idx_d      = 2'd0;
            end
            default: ;
        endcase
    end

    // Status outputs decoded from the registered state.
    always_comb begin
        busy = (state_q != S_IDLE);
        done = (state_q == S_DONE);
    end

    assign A        = idx_q[1];
    assign B        = idx_q[0];
    assign idx      = idx_q;
    assign tt       = tt_q;
    assign tt_valid = tt_valid_q;
    assign err_mask = err_q;

endmodule

// File: tb/tb_gates_sequencer.sv
// Bench for gates_sequencer: a gates model with per-combination fault
// injection drives gate_out; expected tables come from golden constants.
module tb_gates_sequencer;

    localparam int SETTLE = 2;
    localparam int DWELL  = 4;
    localparam int SWEEP  = 4 * (SETTLE + 1 + DWELL);
    localparam int LIMIT  = 500;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        mode = 1'b0;
    logic        step = 1'b0;
    logic [7:0]  gate_out;
    logic        A, B, busy, done, tt_valid;
    logic [1:0]  idx;
    logic [31:0] tt;
    logic [3:0]  err_mask;

    logic [7:0]  flip [4];
    logic [31:0] exp_tt;
    logic [3:0]  exp_err;
    int          pass_cnt = 0;
    int          total_cnt = 0;

    gates_sequencer #(.SETTLE(SETTLE), .DWELL(DWELL)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .mode(mode),
        .step(step), .gate_out(gate_out), .A(A), .B(B), .idx(idx),
        .busy(busy), .done(done), .tt(tt), .tt_valid(tt_valid),
        .err_mask(err_mask)
    );

    always #5 clk = ~clk;

    // Model of the gates block under test, with injectable bit flips.
    assign gate_out = {~(A ^ B), A ^ B, ~(A | B), ~(A & B), A | B, A & B, ~B, ~A}
                      ^ flip[{A, B}];

    function automatic logic [7:0] gold(input int k);
        case (k)
            0: return 8'hB3;
            1: return 8'h59;
            2: return 8'h5A;
            default: return 8'h8C;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic new_flips(input bit faults);
        for (int k = 0; k < 4; k++)
            flip[k] = (faults && $urandom_range(0, 1) == 1) ? 8'($urandom_range(1, 255)) : 8'h00;
    endtask

    task automatic model_capture(input int k);
        exp_tt[8*k +: 8] = gold(k) ^ flip[k];
        exp_err[k]       = (flip[k] != 8'h00);
    endtask

    task automatic wait_done(output int cyc, output bit seen);
        cyc  = 0;
        seen = 1'b0;
        while (cyc < LIMIT && !seen) begin
            tick();
            cyc++;
            if (done) seen = 1'b1;
        end
    endtask

    task automatic wait_idx(input logic [1:0] want, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < LIMIT && !seen; i++) begin
            tick();
            if (idx == want) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        total_cnt++;
        if ({A, B, idx, busy, done, tt_valid, err_mask, tt} !== 43'd0)
            $display("FAIL reset_outputs: got %h want 0",
                     {A, B, idx, busy, done, tt_valid, err_mask, tt});
        else pass_cnt++;
        rst_n = 1'b1;
        tick();
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL reset_idle: busy got %b want 0", busy);
        else pass_cnt++;
    endtask

    task automatic test_auto_sweep(input int n);
        int cyc;
        bit seen;
        for (int it = 0; it < n; it++) begin
            new_flips(it != 0);
            mode  = 1'b0;
            start = 1'b1;
            tick();
            start = 1'b0;
            exp_err = '0;
            total_cnt++;
            if ({busy, idx, tt_valid} !== 4'b1000)
                $display("FAIL auto_start: busy/idx/valid got %b want 1000", {busy, idx, tt_valid});
            else pass_cnt++;
            wait_done(cyc, seen);
            for (int k = 0; k < 4; k++) model_capture(k);
            total_cnt++;
            if (!seen || cyc != SWEEP)
                $display("FAIL auto_latency: got %0d (seen %0d) want %0d", cyc, seen, SWEEP);
            else pass_cnt++;
            total_cnt++;
            if (tt !== exp_tt || err_mask !== exp_err)
                $display("FAIL auto_table: tt %h err %b want tt %h err %b", tt, err_mask, exp_tt, exp_err);
            else pass_cnt++;
            tick();
            total_cnt++;
            if ({done, busy, tt_valid, A, B} !== 5'b00100)
                $display("FAIL auto_end: done/busy/valid/A/B got %b want 00100", {done, busy, tt_valid, A, B});
            else pass_cnt++;
        end
    endtask

    task automatic test_fault_bit6();
        int cyc;
        bit seen;
        flip[0] = 8'h00; flip[1] = 8'h40; flip[2] = 8'h40; flip[3] = 8'h00;
        mode  = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(cyc, seen);
        tick();
        total_cnt++;
        if (tt !== 32'h8C1A19B3 || err_mask !== 4'b0110 || tt_valid !== 1'b1)
            $display("FAIL fault_bit6: tt %h err %b valid %b want 8c1a19b3 0110 1", tt, err_mask, tt_valid);
        else pass_cnt++;
        for (int k = 0; k < 4; k++) model_capture(k);
    endtask

    task automatic test_manual();
        bit seen;
        new_flips(1'b1);
        mode  = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        mode  = 1'b0;
        exp_err = '0;
        step = 1'b1;
        tick();
        step = 1'b0;
        repeat (20) tick();
        model_capture(0);
        total_cnt++;
        if (idx !== 2'd0 || busy !== 1'b1 || tt[7:0] !== exp_tt[7:0])
            $display("FAIL manual_hold: idx %0d busy %b tt0 %h want 0 1 %h", idx, busy, tt[7:0], exp_tt[7:0]);
        else pass_cnt++;
        for (int k = 0; k < 4; k++) begin
            step = 1'b1;
            tick();
            tick();
            step = 1'b0;
            if (k < 3) begin
                wait_idx(2'(k + 1), seen);
                repeat ($urandom_range(6, 12)) tick();
                model_capture(k + 1);
                total_cnt++;
                if (!seen || idx !== 2'(k + 1) || tt[8*(k+1) +: 8] !== exp_tt[8*(k+1) +: 8])
                    $display("FAIL manual_step%0d: idx %0d tt %h want %0d %h", k, idx, tt, k + 1, exp_tt);
                else pass_cnt++;
            end else begin
                seen = 1'b0;
                for (int i = 0; i < 20 && !seen; i++) begin
                    tick();
                    if (done) seen = 1'b1;
                end
                tick();
                total_cnt++;
                if (!seen || tt !== exp_tt || err_mask !== exp_err || tt_valid !== 1'b1 || busy !== 1'b0)
                    $display("FAIL manual_done: seen %0d tt %h err %b valid %b want %h %b 1",
                             seen, tt, err_mask, tt_valid, exp_tt, exp_err);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_abort();
        bit seen;
        bit done_seen;
        new_flips(1'b1);
        mode  = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        exp_err = '0;
        wait_idx(2'd2, seen);
        repeat (SETTLE + 2) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        for (int k = 0; k < 3; k++) model_capture(k);
        total_cnt++;
        if (!seen || {busy, A, B, idx, tt_valid, done} !== 7'b0)
            $display("FAIL abort_idle: busy/A/B/idx/valid/done got %b want 0", {busy, A, B, idx, tt_valid, done});
        else pass_cnt++;
        total_cnt++;
        if (tt !== exp_tt || err_mask !== exp_err)
            $display("FAIL abort_partial: tt %h err %b want %h %b", tt, err_mask, exp_tt, exp_err);
        else pass_cnt++;
        done_seen = 1'b0;
        repeat (40) begin
            tick();
            if (done || busy) done_seen = 1'b1;
        end
        total_cnt++;
        if (done_seen || tt_valid !== 1'b0)
            $display("FAIL abort_quiet: done/busy seen %0d valid %b want 0 0", done_seen, tt_valid);
        else pass_cnt++;
    endtask

    task automatic test_conflict();
        int cyc;
        bit seen;
        start = 1'b1;
        stop  = 1'b1;
        tick();
        tick();
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL start_stop: busy got %b want 0", busy);
        else pass_cnt++;
        stop = 1'b0;
        new_flips(1'b0);
        mode = 1'b0;
        tick();
        exp_err = '0;
        wait_done(cyc, seen);
        tick();
        total_cnt++;
        if (!seen || busy !== 1'b0 || tt_valid !== 1'b1)
            $display("FAIL held_gap: busy %b valid %b want 0 1", busy, tt_valid);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (busy !== 1'b1 || tt_valid !== 1'b0)
            $display("FAIL held_restart: busy %b valid %b want 1 0", busy, tt_valid);
        else pass_cnt++;
        start = 1'b0;
        wait_done(cyc, seen);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        for (int k = 0; k < 4; k++) model_capture(k);
        total_cnt++;
        if (!seen || cyc != SWEEP || tt_valid !== 1'b1 || busy !== 1'b0 || tt !== exp_tt)
            $display("FAIL stop_in_done: cyc %0d valid %b busy %b tt %h want %0d 1 0 %h",
                     cyc, tt_valid, busy, tt, SWEEP, exp_tt);
        else pass_cnt++;
        repeat (3) tick();
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL start_low_idle: busy got %b want 0", busy);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int cyc;
        bit seen;
        new_flips(1'b1);
        mode  = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_idx(2'd1, seen);
        #2;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if (!seen || {A, B, idx, busy, done, tt_valid, err_mask, tt} !== 43'd0)
            $display("FAIL reset_mid: got %h want 0", {A, B, idx, busy, done, tt_valid, err_mask, tt});
        else pass_cnt++;
        tick();
        rst_n = 1'b1;
        tick();
        new_flips(1'b1);
        start = 1'b1;
        tick();
        start = 1'b0;
        exp_err = '0;
        wait_done(cyc, seen);
        tick();
        for (int k = 0; k < 4; k++) model_capture(k);
        total_cnt++;
        if (!seen || cyc != SWEEP || tt !== exp_tt || err_mask !== exp_err || tt_valid !== 1'b1)
            $display("FAIL reset_resweep: cyc %0d tt %h err %b valid %b want %0d %h %b 1",
                     cyc, tt, err_mask, tt_valid, SWEEP, exp_tt, exp_err);
        else pass_cnt++;
    endtask

    initial begin
        for (int k = 0; k < 4; k++) flip[k] = 8'h00;
        exp_tt  = '0;
        exp_err = '0;
        test_reset();
        test_auto_sweep(4);
        test_fault_bit6();
        test_manual();
        test_abort();
        test_conflict();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
